// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, field layout, load-op
// one-hot encodings and exception codes.
package mem_stage_pkg;

    localparam int MEM2WB_LEN  = 199;
    localparam int EXE2MEM_LEN = MEM2WB_LEN + 7;

    // Bit offsets (LSB of each field) inside mem_to_wb_zip
    localparam int WB_IS_ERTN_LSB    = 0;
    localparam int WB_ESUBCODE_LSB   = 1;
    localparam int WB_ECODE_LSB      = 10;
    localparam int WB_EX_VALID_LSB   = 16;
    localparam int WB_VADDR_LSB      = 17;
    localparam int WB_CSR_WVALUE_LSB = 49;
    localparam int WB_CSR_WMASK_LSB  = 81;
    localparam int WB_CSR_NUM_LSB    = 113;
    localparam int WB_CSR_WE_LSB     = 127;
    localparam int WB_CSR_READ_LSB   = 128;
    localparam int WB_PC_LSB         = 129;
    localparam int WB_RF_WDATA_LSB   = 161;
    localparam int WB_RF_WADDR_LSB   = 193;
    localparam int WB_RF_WE_LSB      = 198;

    // Bit offsets of the EXE-only prefix inside exe_to_mem_zip
    localparam int EM_RSVD_LSB     = MEM2WB_LEN;
    localparam int EM_REQ_SENT_LSB = MEM2WB_LEN + 1;
    localparam int EM_LD_OP_LSB    = MEM2WB_LEN + 2;

    // ld_op one-hot: {b, h, w, bu, hu}
    localparam int LD_B_IDX  = 4;
    localparam int LD_H_IDX  = 3;
    localparam int LD_W_IDX  = 2;
    localparam int LD_BU_IDX = 1;
    localparam int LD_HU_IDX = 0;

    localparam logic [4:0] LD_B  = 5'b10000;
    localparam logic [4:0] LD_H  = 5'b01000;
    localparam logic [4:0] LD_W  = 5'b00100;
    localparam logic [4:0] LD_BU = 5'b00010;
    localparam logic [4:0] LD_HU = 5'b00001;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;
    localparam logic [5:0] ECODE_FPD  = 6'h0F;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic [31:0] pc;
        logic        csr_read;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic [31:0] vaddr;
        logic        ex_valid;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        is_ertn;
    } mem2wb_t;

    typedef struct packed {
        logic [4:0] ld_op;
        logic       req_sent;
        logic       rsvd;
        mem2wb_t    wb;
    } exe2mem_t;

    // Saturating counter of responses still owed to flushed requests.
    function automatic logic [1:0] discard_next(input logic [1:0] cnt,
                                                input logic       inc,
                                                input logic       dec);
        logic [1:0] nxt;
        nxt = cnt;
        if (inc && !dec) begin
            if (cnt != 2'd3) nxt = cnt + 2'd1;
        end else if (dec && !inc) begin
            if (cnt != 2'd0) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the SRAM word
// and sign- or zero-extends it according to the one-hot load op.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [4:0]  ld_op_i,
    input  logic [1:0]  vaddr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (vaddr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
    end

    assign half_sel = vaddr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        result_o = rdata_i;
        if (ld_op_i[LD_B_IDX]) begin
            result_o = {{24{byte_sel[7]}}, byte_sel};
        end else if (ld_op_i[LD_BU_IDX]) begin
            result_o = {24'h0, byte_sel};
        end else if (ld_op_i[LD_H_IDX]) begin
            result_o = {{16{half_sel[15]}}, half_sel};
        end else if (ld_op_i[LD_HU_IDX]) begin
            result_o = {16'h0, half_sel};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EXE, waits for the data-SRAM
// response of its request, aligns load data and hands everything to WB.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    output logic                   mem_allowin,
    input  logic                   exe_to_mem_valid,
    input  logic [EXE2MEM_LEN-1:0] exe_to_mem_zip,
    input  logic                   wb_allowin,
    output logic                   mem_to_wb_valid,
    output logic [MEM2WB_LEN-1:0]  mem_to_wb_zip,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    output logic [38:0]            mem_rf_zip,
    output logic                   mem_ex,
    input  logic                   wb_ex
);

    exe2mem_t    in_zip;
    logic        unused_rsvd;

    logic        mem_valid_q, mem_valid_d;
    logic [4:0]  ld_op_q, ld_op_d;
    logic        req_sent_q, req_sent_d;
    mem2wb_t     wb_q, wb_d;
    logic        got_data_q, got_data_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;
    logic [1:0]  discard_cnt_q, discard_cnt_d;

    logic        stale_ok;
    logic        resp_ok;
    logic        waiting;
    logic        ready_go;
    logic        accept;
    logic        has_ld;
    logic [31:0] load_src;
    logic [31:0] load_data;
    logic [31:0] final_wdata;
    logic        load_pending;
    mem2wb_t     wb_out;

    assign in_zip      = exe2mem_t'(exe_to_mem_zip);
    assign unused_rsvd = in_zip.rsvd;

    // A response owed to a flushed request must never reach the current instruction.
    assign stale_ok = data_sram_data_ok & (discard_cnt_q != 2'd0);
    assign resp_ok  = data_sram_data_ok & (discard_cnt_q == 2'd0);

    assign waiting         = mem_valid_q & req_sent_q & ~got_data_q;
    assign ready_go        = ~waiting | resp_ok;
    assign mem_allowin     = ~mem_valid_q | (ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid_q & ready_go;
    assign accept          = exe_to_mem_valid & mem_allowin & ~wb_ex;

    always_comb begin
        mem_valid_d = mem_valid_q;
        ld_op_d     = ld_op_q;
        req_sent_d  = req_sent_q;
        wb_d        = wb_q;
        got_data_d  = got_data_q;
        rdata_buf_d = rdata_buf_q;

        if (waiting && resp_ok) begin
            got_data_d  = 1'b1;
            rdata_buf_d = data_sram_rdata;
        end

        if (wb_ex) begin
            mem_valid_d = 1'b0;
        end else if (mem_allowin) begin
            mem_valid_d = exe_to_mem_valid;
            if (exe_to_mem_valid) begin
                ld_op_d    = in_zip.ld_op;
                req_sent_d = in_zip.req_sent;
                wb_d       = in_zip.wb;
                got_data_d = 1'b0;
            end
        end

        discard_cnt_d = discard_next(discard_cnt_q,
                                     wb_ex & waiting & ~resp_ok,
                                     stale_ok);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q   <= 1'b0;
            ld_op_q       <= '0;
            req_sent_q    <= 1'b0;
            wb_q          <= '0;
            got_data_q    <= 1'b0;
            rdata_buf_q   <= '0;
            discard_cnt_q <= 2'd0;
        end else begin
            mem_valid_q   <= mem_valid_d;
            ld_op_q       <= ld_op_d;
            req_sent_q    <= req_sent_d;
            wb_q          <= wb_d;
            got_data_q    <= got_data_d;
            rdata_buf_q   <= rdata_buf_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    // Live data only on the response cycle; afterwards the buffer keeps the result stable.
    assign load_src = (waiting & resp_ok) ? data_sram_rdata : rdata_buf_q;
    assign has_ld   = |ld_op_q;

    mem_load_align u_load_align (
        .ld_op_i    (ld_op_q),
        .vaddr_lo_i (wb_q.vaddr[1:0]),
        .rdata_i    (load_src),
        .result_o   (load_data)
    );

    assign final_wdata = has_ld ? load_data : wb_q.rf_wdata;

    always_comb begin
        wb_out          = wb_q;
        wb_out.rf_wdata = final_wdata;
    end

    assign mem_to_wb_zip = wb_out;
    assign mem_ex        = mem_valid_q & (wb_q.ex_valid | wb_q.is_ertn);
    assign load_pending  = mem_valid_q & has_ld & ~ready_go;

    assign mem_rf_zip = mem_valid_q
                      ? {load_pending, wb_q.rf_we & ~mem_ex, wb_q.rf_waddr, final_wdata}
                      : 39'h0;

endmodule
